// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: drains the receiver FIFO, tracks make/break/E0.
// Optional shift-modifier handling is enabled with `define PS2_SHIFT_EN.
module ps2_key_decoder #(
   parameter int unsigned CNT_MAX = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ps2_byte,
   input  logic       ps2_ready,
   input  logic       ps2_overflow,
   output logic       ps2_nextdata_n,
   output logic [7:0] key_num,
   output logic [7:0] asc_num,
   output logic [7:0] key_times,
   output logic       key_valid
);

   localparam logic [7:0] CMAX = 8'(CNT_MAX);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WAIT
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] code_q, code_d;
   logic       nxt_n_q, nxt_n_d;
   logic [7:0] key_q, key_d;
   logic [7:0] asc_q, asc_d;
   logic [7:0] times_q, times_d;
   logic       valid_q, valid_d;
   logic       brk_q, brk_d;
   logic       ext_q, ext_d;
   logic       ovf_q;
   logic       ovf_rise;
   logic       is_mod;
   logic       repeat_hit;

   function automatic logic [7:0] ascii_of(input logic [7:0] c,
                                           input logic       up);
      logic [7:0] a;
      a = 8'h00;
      case (c)
         8'h1C: a = 8'h61;
         8'h32: a = 8'h62;
         8'h21: a = 8'h63;
         8'h23: a = 8'h64;
         8'h24: a = 8'h65;
         8'h2B: a = 8'h66;
         8'h34: a = 8'h67;
         8'h33: a = 8'h68;
         8'h43: a = 8'h69;
         8'h3B: a = 8'h6A;
         8'h42: a = 8'h6B;
         8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;
         8'h31: a = 8'h6E;
         8'h44: a = 8'h6F;
         8'h4D: a = 8'h70;
         8'h15: a = 8'h71;
         8'h2D: a = 8'h72;
         8'h1B: a = 8'h73;
         8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;
         8'h2A: a = 8'h76;
         8'h1D: a = 8'h77;
         8'h22: a = 8'h78;
         8'h35: a = 8'h79;
         8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;
         8'h16: a = 8'h31;
         8'h1E: a = 8'h32;
         8'h26: a = 8'h33;
         8'h25: a = 8'h34;
         8'h2E: a = 8'h35;
         8'h36: a = 8'h36;
         8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;
         8'h46: a = 8'h39;
         8'h29: a = 8'h20;
         8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      // Only the lowercase letter range is shifted.
      if (up && (a >= 8'h61) && (a <= 8'h7A)) begin
         a = a - 8'h20;
      end
      return a;
   endfunction

`ifdef PS2_SHIFT_EN
   logic shift_q, shift_d;

   assign is_mod = (code_q == 8'h12) || (code_q == 8'h59);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
      end
   end
`else
   logic shift_q;

   assign shift_q = 1'b0;
   assign is_mod  = 1'b0;
`endif

   assign ovf_rise   = ps2_overflow && !ovf_q;
   assign repeat_hit = valid_q && (code_q == key_q);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      nxt_n_d = 1'b1;
      key_d   = key_q;
      asc_d   = asc_q;
      times_d = times_q;
      valid_d = valid_q;
      brk_d   = brk_q;
      ext_d   = ext_q;
`ifdef PS2_SHIFT_EN
      shift_d = shift_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (ps2_ready) begin
               code_d  = ps2_byte;
               nxt_n_d = 1'b0;
               state_d = S_POP;
            end
         end
         S_POP: begin
            state_d = S_WAIT;
            if (code_q == 8'hF0) begin
               brk_d = 1'b1;
            end else if (code_q == 8'hE0) begin
               ext_d = 1'b1;
            end else if (brk_q) begin
               brk_d = 1'b0;
               ext_d = 1'b0;
               if (is_mod) begin
`ifdef PS2_SHIFT_EN
                  shift_d = 1'b0;
`endif
               end else if (repeat_hit) begin
                  valid_d = 1'b0;
               end
            end else begin
               ext_d = 1'b0;
               if (is_mod) begin
`ifdef PS2_SHIFT_EN
                  shift_d = 1'b1;
`endif
               end else if (!repeat_hit) begin
                  key_d   = code_q;
                  asc_d   = ext_q ? 8'h00 : ascii_of(code_q, shift_q);
                  valid_d = 1'b1;
                  times_d = (times_q == CMAX) ? 8'h00 : times_q + 8'h01;
               end
            end
         end
         S_WAIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Lost bytes make prefix state untrustworthy; drop it.
      if (ovf_rise) begin
         brk_d   = 1'b0;
         ext_d   = 1'b0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         code_q  <= 8'h00;
         nxt_n_q <= 1'b1;
         key_q   <= 8'h00;
         asc_q   <= 8'h00;
         times_q <= 8'h00;
         valid_q <= 1'b0;
         brk_q   <= 1'b0;
         ext_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         nxt_n_q <= nxt_n_d;
         key_q   <= key_d;
         asc_q   <= asc_d;
         times_q <= times_d;
         valid_q <= valid_d;
         brk_q   <= brk_d;
         ext_q   <= ext_d;
         ovf_q   <= ps2_overflow;
      end
   end

   assign ps2_nextdata_n = nxt_n_q;
   assign key_num        = key_q;
   assign asc_num        = asc_q;
   assign key_times      = times_q;
   assign key_valid      = valid_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a receiver-FIFO model and
// a scoreboard of expected outputs per popped byte.
module tb_ps2_key_decoder;

   localparam int CNT = 99;

   logic       clk;
   logic       rst;
   logic [7:0] ps2_byte;
   logic       ps2_ready;
   logic       ps2_overflow;
   logic       ps2_nextdata_n;
   logic [7:0] key_num;
   logic [7:0] asc_num;
   logic [7:0] key_times;
   logic       key_valid;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  fifo[$];
   logic [31:0] exq[$];
   int          pulse_cyc[$];
   bit          cmp_now = 0;
   bit          prev_low = 0;
   bit          manual = 0;

   logic [7:0] m_key, m_asc, m_times;
   logic       m_valid, m_brk, m_ext, m_shift;

   ps2_key_decoder #(.CNT_MAX(CNT)) dut (
      .clk            (clk),
      .rst            (rst),
      .ps2_byte       (ps2_byte),
      .ps2_ready      (ps2_ready),
      .ps2_overflow   (ps2_overflow),
      .ps2_nextdata_n (ps2_nextdata_n),
      .key_num        (key_num),
      .asc_num        (asc_num),
      .key_times      (key_times),
      .key_valid      (key_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_ascii(input logic [7:0] c,
                                            input logic sh);
      logic [7:0] a;
      case (c)
         8'h1C: a = "a"; 8'h32: a = "b"; 8'h21: a = "c"; 8'h23: a = "d";
         8'h24: a = "e"; 8'h2B: a = "f"; 8'h34: a = "g"; 8'h33: a = "h";
         8'h43: a = "i"; 8'h3B: a = "j"; 8'h42: a = "k"; 8'h4B: a = "l";
         8'h3A: a = "m"; 8'h31: a = "n"; 8'h44: a = "o"; 8'h4D: a = "p";
         8'h15: a = "q"; 8'h2D: a = "r"; 8'h1B: a = "s"; 8'h2C: a = "t";
         8'h3C: a = "u"; 8'h2A: a = "v"; 8'h1D: a = "w"; 8'h22: a = "x";
         8'h35: a = "y"; 8'h1A: a = "z";
         8'h45: a = "0"; 8'h16: a = "1"; 8'h1E: a = "2"; 8'h26: a = "3";
         8'h25: a = "4"; 8'h2E: a = "5"; 8'h36: a = "6"; 8'h3D: a = "7";
         8'h3E: a = "8"; 8'h46: a = "9";
         8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
         default: a = 8'h00;
      endcase
      if (sh && a >= "a" && a <= "z") a = a - 8'd32;
      return a;
   endfunction

   task automatic model_reset();
      m_key = 0; m_asc = 0; m_times = 0;
      m_valid = 0; m_brk = 0; m_ext = 0; m_shift = 0;
   endtask

   task automatic model(input logic [7:0] c);
      bit modk;
`ifdef PS2_SHIFT_EN
      modk = (c == 8'h12) || (c == 8'h59);
`else
      modk = 0;
`endif
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0) m_ext = 1;
      else if (m_brk) begin
         if (modk) m_shift = 0;
         else if (m_valid && c == m_key) m_valid = 0;
         m_brk = 0; m_ext = 0;
      end else begin
         if (modk) m_shift = 1;
         else if (!(m_valid && c == m_key)) begin
            m_key = c;
            m_asc = m_ext ? 8'h00 : ref_ascii(c, m_shift);
            m_valid = 1;
            m_times = (m_times == CNT) ? 8'd0 : m_times + 8'd1;
         end
         m_ext = 0;
      end
   endtask

   task automatic tick();
      logic [31:0] e;
      logic [7:0]  b;
      @(negedge clk);
      cyc++;
      if (cmp_now) begin
         e = exq.pop_front();
         chk("sb_key", key_num, e[31:24]);
         chk("sb_asc", asc_num, e[23:16]);
         chk("sb_times", key_times, e[15:8]);
         chk("sb_valid", {7'd0, key_valid}, {7'd0, e[0]});
         cmp_now = 0;
      end
      if (!ps2_nextdata_n) begin
         chk("pulse_width", {7'd0, prev_low}, 8'd0);
         pulse_cyc.push_back(cyc);
         if (!manual && fifo.size() != 0) begin
            b = fifo.pop_front();
            model(b);
            exq.push_back({m_key, m_asc, m_times, 7'd0, m_valid});
            cmp_now = 1;
         end
      end
      prev_low = !ps2_nextdata_n;
      if (!manual) begin
         ps2_ready = fifo.size() != 0;
         ps2_byte  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      end
   endtask

   task automatic drain(input int bound);
      int n = 0;
      while ((fifo.size() != 0 || exq.size() != 0) && n < bound) begin
         tick();
         n++;
      end
      total++;
      assert (n < bound) else begin
         bad++;
         $error("FAIL drain_timeout got=%0d exp<%0d", n, bound);
      end
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1;
      fifo.delete();
      tick();
      tick();
      rst = 0;
      model_reset();
      prev_low = 0;
   endtask

   initial begin
      rst = 1;
      ps2_byte = 0;
      ps2_ready = 0;
      ps2_overflow = 0;
      model_reset();
      tick();
      chk("rst_nextdata_n", {7'd0, ps2_nextdata_n}, 8'd1);
      chk("rst_key", key_num, 8'h00);
      chk("rst_asc", asc_num, 8'h00);
      chk("rst_times", key_times, 8'h00);
      chk("rst_valid", {7'd0, key_valid}, 8'd0);
      tick();
      rst = 0;

      fifo.push_back(8'h1C);
      drain(50);
      chk("a_key", key_num, 8'h1C);
      chk("a_asc", asc_num, 8'h61);
      chk("a_times", key_times, 8'd1);
      chk("a_valid", {7'd0, key_valid}, 8'd1);
      fifo.push_back(8'hF0);
      fifo.push_back(8'h1C);
      drain(50);
      chk("a_rel_valid", {7'd0, key_valid}, 8'd0);
      chk("a_rel_times", key_times, 8'd1);

      do_reset();
      pulse_cyc.delete();
      fifo.push_back(8'h1C);
      fifo.push_back(8'h1C);
      fifo.push_back(8'h1C);
      fifo.push_back(8'hF0);
      fifo.push_back(8'h1C);
      drain(100);
      chk("rep_times", key_times, 8'd1);
      chk("rep_valid", {7'd0, key_valid}, 8'd0);
      chk("rep_pulses", 8'(pulse_cyc.size()), 8'd5);
      for (int i = 1; i < pulse_cyc.size(); i++) begin
         chk("rep_spacing", 8'(pulse_cyc[i] - pulse_cyc[i-1]), 8'd3);
      end

      do_reset();
      for (int i = 0; i < 99; i++) begin
         fifo.push_back(8'(8'h60 + i));
         fifo.push_back(8'hF0);
         fifo.push_back(8'(8'h60 + i));
      end
      drain(2000);
      chk("pre_times", key_times, 8'd99);
      fifo.push_back(8'h45);
      drain(50);
      chk("wrap_times", key_times, 8'd0);
      chk("wrap_asc", asc_num, 8'h30);

      fifo.push_back(8'hE0);
      fifo.push_back(8'h75);
      drain(50);
      chk("ext_key", key_num, 8'h75);
      chk("ext_asc", asc_num, 8'h00);
      chk("ext_times", key_times, 8'd1);

`ifdef PS2_SHIFT_EN
      do_reset();
      fifo.push_back(8'h12);
      fifo.push_back(8'h1C);
      drain(50);
      chk("sh_up_asc", asc_num, 8'h41);
      fifo.push_back(8'hF0);
      fifo.push_back(8'h1C);
      fifo.push_back(8'hF0);
      fifo.push_back(8'h12);
      fifo.push_back(8'h1C);
      drain(100);
      chk("sh_low_asc", asc_num, 8'h61);
      chk("sh_times", key_times, 8'd2);
`endif

      fifo.push_back(8'h29);
      drain(50);
      chk("ovf_pre_valid", {7'd0, key_valid}, 8'd1);
      ps2_overflow = 1;
      tick();
      tick();
      chk("ovf_valid", {7'd0, key_valid}, 8'd0);
      m_valid = 0;
      m_brk = 0;
      m_ext = 0;
      ps2_overflow = 0;
      fifo.push_back(8'h29);
      drain(50);
      chk("ovf_repress_asc", asc_num, 8'h20);
      chk("ovf_repress_valid", {7'd0, key_valid}, 8'd1);

      manual = 1;
      ps2_byte = 8'h16;
      ps2_ready = 1;
      begin
         int n = 0;
         while (ps2_nextdata_n && n < 20) begin
            tick();
            n++;
         end
         chk("mid_pop_seen", {7'd0, ps2_nextdata_n}, 8'd0);
      end
      rst = 1;
      #1;
      chk("mid_rst_nextdata_n", {7'd0, ps2_nextdata_n}, 8'd1);
      chk("mid_rst_key", key_num, 8'h00);
      chk("mid_rst_asc", asc_num, 8'h00);
      chk("mid_rst_times", key_times, 8'h00);
      chk("mid_rst_valid", {7'd0, key_valid}, 8'd0);
      tick();
      rst = 0;
      prev_low = 0;
      tick();
      chk("post_rst_pop", {7'd0, ps2_nextdata_n}, 8'd0);
      tick();
      ps2_ready = 0;
      chk("post_rst_key", key_num, 8'h16);
      chk("post_rst_asc", asc_num, 8'h31);
      chk("post_rst_times", key_times, 8'd1);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
